chip8_sprite_engine: RTL and testbench

Parametrised DXYN sprite draw engine. Given a sprite address, coordinates and a row count, it fetches sprite bytes from main memory and XORs them into a byte-packed framebuffer by read-modify-write. It reports collisions. It generalises the CPU's inline draw path with configurable display size, 16x16 SUPER-CHIP sprites, and clip or wrap edge modes, and sits between the CPU execute stage, main memory and the display framebuffer RAM.

---
 rtl/chip8_pkg.sv | 31 +++
 rtl/chip8_sprite_shifter.sv | 22 ++
 rtl/chip8_sprite_engine.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_chip8_sprite_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 sprite draw engine.
// Holds the FSM encoding, framebuffer geometry helpers and the pixel bit-order constant.
// Pure definitions: no logic, no latency, no backpressure.
package chip8_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_BUILD,
    ST_FB_RD,
    ST_FB_WAIT,
    ST_FB_WR,
    ST_ROW_END,
    ST_FIN
  } state_t;

  // MSB of a sprite or framebuffer byte is the leftmost pixel.
  localparam bit SPR_MSB_LEFT = 1'b1;

  // Framebuffer bytes per display row.
  function automatic int cols_of(input int disp_w);
    return disp_w / 8;
  endfunction

  // Framebuffer byte-address width.
  function automatic int fb_aw_of(input int disp_w, input int disp_h);
    return $clog2(disp_w * disp_h / 8);
  endfunction

endpackage

// File: rtl/chip8_sprite_shifter.sv
// Aligns a 16-bit sprite row to a byte grid by shifting right 0..7 pixels into 24 bits.
// Purely combinational, zero latency.
// No handshake; the mask marks which of the three pattern bytes can carry pixels.
module chip8_sprite_shifter
  import chip8_pkg::*;
(
  input  logic [15:0] row,
  input  logic [2:0]  sh,
  input  logic        wide,
  output logic [23:0] pat,
  output logic [2:0]  mask
);

  // Shift the row toward higher pixel columns and flag bytes the row can reach.
  always_comb begin
    pat     = SPR_MSB_LEFT ? ({row, 8'h00} >> sh) : ({8'h00, row} << sh);
    mask[0] = 1'b1;
    mask[1] = wide | (sh != 3'd0);
    mask[2] = wide & (sh != 3'd0);
  end

endmodule

// File: rtl/chip8_sprite_engine.sv
// DXYN sprite draw engine: fetches sprite rows and XORs them into a byte-packed framebuffer.
// Latency: per row MEM_LAT+1 cycles per sprite byte fetched, plus 3 cycles per touched fb byte.
// start is ignored while busy; memories are assumed always ready with fixed latency.
module chip8_sprite_engine
  import chip8_pkg::*;
#(
  parameter  int DISP_W  = 64,
  parameter  int DISP_H  = 32,
  parameter  int ADDR_W  = 12,
  parameter  int MEM_LAT = 2,
  localparam int FB_AW   = fb_aw_of(DISP_W, DISP_H)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        x_in,
  input  logic [7:0]        y_in,
  input  logic [3:0]        n_in,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              wide_en,
  input  logic              clip_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              fb_rd,
  output logic              fb_wr,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [4:0]        rows_hit
);

  localparam int         COLS      = cols_of(DISP_W);
  localparam int         CB        = $clog2(COLS);
  localparam int         RB        = $clog2(DISP_H);
  localparam logic [5:0] COLS6     = 6'(COLS);
  localparam logic [8:0] LAST_ROW9 = 9'(DISP_H - 1);
  localparam logic [7:0] XMASK     = 8'(DISP_W - 1);
  localparam logic [7:0] YMASK     = 8'(DISP_H - 1);
  localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 2);

  state_t state_q, state_d;
  logic [7:0]        x0_q, x0_d, y0_q, y0_d;
  logic [4:0]        nrows_q, nrows_d, r_q, r_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wide_q, wide_d, clip_q, clip_d;
  logic [1:0]        k_q, k_d, wait_q, wait_d;
  logic              second_q, second_d, cap_hi_q, cap_hi_d, cap_lo_q, cap_lo_d;
  logic [15:0]       row_q, row_d;
  logic              flag_q, flag_d;
  logic              mem_rd_q, mem_rd_d, fb_rd_q, fb_rd_d, fb_wr_q, fb_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
  logic [7:0]        fb_wdata_q, fb_wdata_d;
  logic              busy_q, busy_d, done_q, done_d, coll_q, coll_d;
  logic [4:0]        hits_q, hits_d;

  logic [23:0] pat;
  logic [2:0]  mask, elig;
  logic [7:0]  pb [3];
  logic [5:0]  colsum [3];
  logic [8:0]  yr;
  logic [7:0]  pb_k;
  logic [1:0]  first_k, next_k, sel_k;
  logic        first_vld, next_vld, fetch_done;
  logic [4:0]  rn;
  logic [5:0]  col_sel;
  logic [FB_AW-1:0] tgt_addr;

  // Sprite row register picks up memory data in the cycle it is valid.
  always_comb begin
    row_d = row_q;
    if (cap_hi_q) row_d = {mem_rdata, 8'h00};
    if (cap_lo_q) row_d = {row_q[15:8], mem_rdata};
  end

  chip8_sprite_shifter u_shift (
    .row  (row_d),
    .sh   (x0_q[2:0]),
    .wide (wide_q),
    .pat  (pat),
    .mask (mask)
  );

  // Per-byte targets: column, clip/skip eligibility and the next byte to visit.
  always_comb begin
    pb[0] = pat[23:16];
    pb[1] = pat[15:8];
    pb[2] = pat[7:0];
    yr    = {1'b0, y0_q} + {4'b0000, r_q};
    for (int k = 0; k < 3; k++) begin
      colsum[k] = {1'b0, x0_q[7:3]} + 6'(k);
      elig[k]   = mask[k] && (pb[k] != 8'h00) && !(clip_q && (colsum[k] >= COLS6));
    end
    first_vld = 1'b0;
    first_k   = 2'd0;
    next_vld  = 1'b0;
    next_k    = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (elig[k]) begin
        first_vld = 1'b1;
        first_k   = 2'(k);
      end
      if (elig[k] && (2'(k) > k_q)) begin
        next_vld = 1'b1;
        next_k   = 2'(k);
      end
    end
    sel_k = (state_q == ST_BUILD) ? first_k : next_k;
    case (sel_k)
      2'd1:    col_sel = colsum[1];
      2'd2:    col_sel = colsum[2];
      default: col_sel = colsum[0];
    endcase
    case (k_q)
      2'd1:    pb_k = pb[1];
      2'd2:    pb_k = pb[2];
      default: pb_k = pb[0];
    endcase
    tgt_addr = {yr[RB-1:0], col_sel[CB-1:0]};
  end

  // Draw sequencer: next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    nrows_d    = nrows_q;
    r_d        = r_q;
    base_d     = base_q;
    wide_d     = wide_q;
    clip_d     = clip_q;
    k_d        = k_q;
    wait_d     = wait_q;
    second_d   = second_q;
    cap_hi_d   = 1'b0;
    cap_lo_d   = 1'b0;
    flag_d     = flag_q;
    mem_rd_d   = 1'b0;
    fb_rd_d    = 1'b0;
    fb_wr_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    done_d     = 1'b0;
    coll_d     = coll_q;
    hits_d     = hits_q;
    fetch_done = 1'b0;
    rn         = r_q + 5'd1;
    case (state_q)
      ST_IDLE: if (start) begin
        x0_d     = x_in & XMASK;
        y0_d     = y_in & YMASK;
        wide_d   = wide_en && (n_in == 4'd0);
        clip_d   = clip_en;
        base_d   = i_addr;
        nrows_d  = (wide_en && (n_in == 4'd0)) ? 5'd16 : {1'b0, n_in};
        r_d      = 5'd0;
        flag_d   = 1'b0;
        coll_d   = 1'b0;
        hits_d   = 5'd0;
        second_d = 1'b0;
        if (!wide_en && (n_in == 4'd0)) begin
          state_d = ST_ROW_END;
        end else begin
          state_d    = ST_FETCH;
          mem_rd_d   = 1'b1;
          mem_addr_d = i_addr;
        end
      end
      ST_FETCH: begin
        if (MEM_LAT == 1) fetch_done = 1'b1;
        else begin
          state_d = ST_FETCH_WAIT;
          wait_d  = 2'd0;
        end
      end
      ST_FETCH_WAIT: begin
        if (wait_q == WAIT_LAST) fetch_done = 1'b1;
        else wait_d = wait_q + 2'd1;
      end
      ST_BUILD: begin
        if (first_vld) begin
          state_d   = ST_FB_RD;
          k_d       = first_k;
          fb_rd_d   = 1'b1;
          fb_addr_d = tgt_addr;
        end else begin
          state_d = ST_ROW_END;
        end
      end
      ST_FB_RD: state_d = ST_FB_WAIT;
      ST_FB_WAIT: begin
        state_d    = ST_FB_WR;
        fb_wr_d    = 1'b1;
        fb_wdata_d = fb_rdata ^ pb_k;
        if ((fb_rdata & pb_k) != 8'h00) flag_d = 1'b1;
      end
      ST_FB_WR: begin
        if (next_vld) begin
          state_d   = ST_FB_RD;
          k_d       = next_k;
          fb_rd_d   = 1'b1;
          fb_addr_d = tgt_addr;
        end else begin
          state_d = ST_ROW_END;
        end
      end
      ST_ROW_END: begin
        if (flag_q) begin
          coll_d = 1'b1;
          if (hits_q != 5'd16) hits_d = hits_q + 5'd1;
        end
        flag_d   = 1'b0;
        r_d      = rn;
        second_d = 1'b0;
        if ((rn >= nrows_q) || (clip_q && (yr >= LAST_ROW9))) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_FETCH;
          mem_rd_d   = 1'b1;
          mem_addr_d = base_q + (wide_q ? ADDR_W'({rn, 1'b0}) : ADDR_W'(rn));
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (fetch_done) begin
      cap_hi_d = !second_q;
      cap_lo_d = second_q;
      if (wide_q && !second_q) begin
        state_d    = ST_FETCH;
        mem_rd_d   = 1'b1;
        second_d   = 1'b1;
        mem_addr_d = mem_addr_q + ADDR_W'(1);
      end else begin
        state_d = ST_BUILD;
      end
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
  end

  // State and registered outputs; reset abandons any draw at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      nrows_q    <= '0;
      r_q        <= '0;
      base_q     <= '0;
      wide_q     <= 1'b0;
      clip_q     <= 1'b0;
      k_q        <= '0;
      wait_q     <= '0;
      second_q   <= 1'b0;
      cap_hi_q   <= 1'b0;
      cap_lo_q   <= 1'b0;
      row_q      <= '0;
      flag_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      fb_rd_q    <= 1'b0;
      fb_wr_q    <= 1'b0;
      mem_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      hits_q     <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      nrows_q    <= nrows_d;
      r_q        <= r_d;
      base_q     <= base_d;
      wide_q     <= wide_d;
      clip_q     <= clip_d;
      k_q        <= k_d;
      wait_q     <= wait_d;
      second_q   <= second_d;
      cap_hi_q   <= cap_hi_d;
      cap_lo_q   <= cap_lo_d;
      row_q      <= row_d;
      flag_q     <= flag_d;
      mem_rd_q   <= mem_rd_d;
      fb_rd_q    <= fb_rd_d;
      fb_wr_q    <= fb_wr_d;
      mem_addr_q <= mem_addr_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      coll_q     <= coll_d;
      hits_q     <= hits_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign fb_rd     = fb_rd_q;
  assign fb_wr     = fb_wr_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = coll_q;
  assign rows_hit  = hits_q;

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Directed bench for chip8_sprite_engine with a 2-cycle main memory and a 64x32 framebuffer.
// Expected writes, addresses and collision results are hand-computed per test.
// Memories never stall; every wait on the DUT is bounded.
module tb_chip8_sprite_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  x_in, y_in;
  logic [3:0]  n_in;
  logic [11:0] i_addr;
  logic        wide_en, clip_en;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        fb_rd, fb_wr;
  logic [7:0]  fb_addr;
  logic [7:0]  fb_wdata;
  logic [7:0]  fb_rdata = 8'h00;
  logic        busy, done, collision;
  logic [4:0]  rows_hit;

  always #5 clk = ~clk;

  chip8_sprite_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .n_in      (n_in),
    .i_addr    (i_addr),
    .wide_en   (wide_en),
    .clip_en   (clip_en),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .fb_rd     (fb_rd),
    .fb_wr     (fb_wr),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_rdata  (fb_rdata),
    .busy      (busy),
    .done      (done),
    .collision (collision),
    .rows_hit  (rows_hit)
  );

  logic [7:0]  mem [4096];
  logic [7:0]  fb  [256];
  logic        fb_clr = 1'b0;
  logic        m_vld = 1'b0;
  logic [11:0] m_a = '0;
  logic [7:0]  wa [$];
  logic [7:0]  wd [$];
  logic [11:0] ma [$];
  int          n_fbrd = 0, n_done = 0, n_clash = 0;
  int          n_vec = 0, n_bad = 0;
  int          wb, mb, fb0, d0;

  // Memory and framebuffer models plus strobe logging.
  always @(posedge clk) begin
    m_vld <= mem_rd;
    m_a   <= mem_addr;
    if (m_vld) mem_rdata <= mem[m_a];
    if (mem_rd) ma.push_back(mem_addr);
    if (fb_clr) begin
      for (int i = 0; i < 256; i++) fb[i] <= 8'h00;
    end else begin
      if (fb_rd) fb_rdata <= fb[fb_addr];
      if (fb_wr) begin
        fb[fb_addr] <= fb_wdata;
        wa.push_back(fb_addr);
        wd.push_back(fb_wdata);
      end
    end
    if (fb_rd) n_fbrd <= n_fbrd + 1;
    if (done) n_done <= n_done + 1;
    if ((32'(mem_rd) + 32'(fb_rd) + 32'(fb_wr)) > 1) n_clash <= n_clash + 1;
  end

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic mark();
    wb  = wa.size();
    mb  = ma.size();
    fb0 = n_fbrd;
    d0  = n_done;
  endtask

  task automatic clear_fb();
    @(negedge clk) fb_clr = 1'b1;
    @(negedge clk) fb_clr = 1'b0;
  endtask

  task automatic set_req(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                         input logic [11:0] a, input logic w, input logic c);
    x_in = x; y_in = y; n_in = n; i_addr = a; wide_en = w; clip_en = c;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    expect_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic run_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                          input logic [11:0] a, input logic w, input logic c, input string tag);
    mark();
    @(negedge clk);
    set_req(x, y, n, a, w, c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'hF0;
    mem[12'h210] = 8'hFF;
    mem[12'h211] = 8'hFF;
    mem[12'h300] = 8'h81;
    mem[12'h320] = 8'h3C;
    for (int i = 0; i < 32; i++) mem[12'h400 + i] = (i % 2 == 0) ? 8'hAA : 8'h55;

    reset_n = 1'b0;
    start   = 1'b0;
    set_req(8'd0, 8'd0, 4'd0, 12'h000, 1'b0, 1'b0);
    fb_clr  = 1'b1;
    repeat (3) @(negedge clk);
    fb_clr  = 1'b0;
    expect_eq("rst_busy", 32'(busy), 0);
    expect_eq("rst_done", 32'(done), 0);
    expect_eq("rst_strobes", {29'd0, mem_rd, fb_rd, fb_wr}, 0);
    expect_eq("rst_coll", {26'd0, collision, rows_hit}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: narrow sprite, shift by 3, second pattern byte empty.
    run_draw(8'd3, 8'd0, 4'd1, 12'h200, 1'b0, 1'b1, "t1_done");
    expect_eq("t1_nwr", wa.size() - wb, 1);
    expect_eq("t1_addr", 32'(wa[wb]), 32'h00);
    expect_eq("t1_data", 32'(wd[wb]), 32'h1E);
    expect_eq("t1_nrd", ma.size() - mb, 1);
    expect_eq("t1_maddr", 32'(ma[mb]), 32'h200);
    expect_eq("t1_coll", 32'(collision), 0);
    expect_eq("t1_hits", 32'(rows_hit), 0);

    // 2: same draw erases the pixels and collides.
    run_draw(8'd3, 8'd0, 4'd1, 12'h200, 1'b0, 1'b1, "t2_done");
    expect_eq("t2_nwr", wa.size() - wb, 1);
    expect_eq("t2_data", 32'(wd[wb]), 32'h00);
    expect_eq("t2_coll", 32'(collision), 1);
    expect_eq("t2_hits", 32'(rows_hit), 1);

    // 3a: wrap on both axes.
    clear_fb();
    run_draw(8'd60, 8'd31, 4'd2, 12'h210, 1'b0, 1'b0, "t3w_done");
    expect_eq("t3w_nwr", wa.size() - wb, 4);
    expect_eq("t3w_a0", 32'(wa[wb]),     255); expect_eq("t3w_d0", 32'(wd[wb]),     32'h0F);
    expect_eq("t3w_a1", 32'(wa[wb + 1]), 248); expect_eq("t3w_d1", 32'(wd[wb + 1]), 32'hF0);
    expect_eq("t3w_a2", 32'(wa[wb + 2]), 7);   expect_eq("t3w_d2", 32'(wd[wb + 2]), 32'h0F);
    expect_eq("t3w_a3", 32'(wa[wb + 3]), 0);   expect_eq("t3w_d3", 32'(wd[wb + 3]), 32'hF0);
    expect_eq("t3w_coll", 32'(collision), 0);

    // 3b: same stimulus clipped: right column dropped, second row terminates.
    clear_fb();
    run_draw(8'd60, 8'd31, 4'd2, 12'h210, 1'b0, 1'b1, "t3c_done");
    expect_eq("t3c_nwr", wa.size() - wb, 1);
    expect_eq("t3c_a0", 32'(wa[wb]), 255);
    expect_eq("t3c_d0", 32'(wd[wb]), 32'h0F);
    expect_eq("t3c_nrd", ma.size() - mb, 1);

    // 4: 16x16 sprite, then redraw to saturate rows_hit at 16.
    clear_fb();
    run_draw(8'd0, 8'd0, 4'd0, 12'h400, 1'b1, 1'b1, "t4_done");
    expect_eq("t4_nwr", wa.size() - wb, 32);
    for (int r = 0; r < 16; r++) begin
      expect_eq("t4_a_even", 32'(wa[wb + 2*r]),     32'(8*r));
      expect_eq("t4_d_even", 32'(wd[wb + 2*r]),     32'hAA);
      expect_eq("t4_a_odd",  32'(wa[wb + 2*r + 1]), 32'(8*r + 1));
      expect_eq("t4_d_odd",  32'(wd[wb + 2*r + 1]), 32'h55);
    end
    expect_eq("t4_nrd", ma.size() - mb, 32);
    for (int k = 0; k < 32; k++) expect_eq("t4_maddr", 32'(ma[mb + k]), 32'(12'h400 + k));
    expect_eq("t4_coll", 32'(collision), 0);
    run_draw(8'd0, 8'd0, 4'd0, 12'h400, 1'b1, 1'b1, "t4r_done");
    expect_eq("t4r_d_last", 32'(wd[wb + 31]), 32'h00);
    expect_eq("t4r_coll", 32'(collision), 1);
    expect_eq("t4r_hits", 32'(rows_hit), 16);

    // 5a: a start while busy is ignored.
    clear_fb();
    mark();
    @(negedge clk);
    set_req(8'd8, 8'd1, 4'd1, 12'h300, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    expect_eq("t5_busy_2nd", 32'(busy), 1);
    set_req(8'd16, 8'd5, 4'd1, 12'h320, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("t5_done");
    repeat (40) @(negedge clk);
    expect_eq("t5_nwr", wa.size() - wb, 1);
    expect_eq("t5_addr", 32'(wa[wb]), 9);
    expect_eq("t5_data", 32'(wd[wb]), 32'h81);
    expect_eq("t5_ndone", n_done - d0, 1);

    // 5b: reset asserted during a framebuffer write.
    clear_fb();
    mark();
    @(negedge clk);
    set_req(8'd60, 8'd31, 4'd2, 12'h210, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 200 && !fb_wr; c++) @(negedge clk);
    expect_eq("t5r_saw_wr", 32'(fb_wr), 1);
    reset_n = 1'b0;
    #1;
    expect_eq("t5r_fb_wr", 32'(fb_wr), 0);
    expect_eq("t5r_busy", 32'(busy), 0);
    expect_eq("t5r_done", 32'(done), 0);
    @(negedge clk) reset_n = 1'b1;
    clear_fb();
    run_draw(8'd0, 8'd2, 4'd1, 12'h320, 1'b0, 1'b1, "t5r2_done");
    expect_eq("t5r2_nwr", wa.size() - wb, 1);
    expect_eq("t5r2_addr", 32'(wa[wb]), 16);
    expect_eq("t5r2_data", 32'(wd[wb]), 32'h3C);
    expect_eq("t5r2_coll", 32'(collision), 0);

    // 6: narrow N=0 is a no-op draw.
    mark();
    @(negedge clk);
    set_req(8'd5, 8'd5, 4'd0, 12'h200, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    expect_eq("t6_busy", 32'(busy), 1);
    expect_eq("t6_done_early", 32'(done), 0);
    @(negedge clk);
    expect_eq("t6_done", 32'(done), 1);
    expect_eq("t6_coll", 32'(collision), 0);
    expect_eq("t6_nrd", ma.size() - mb, 0);
    expect_eq("t6_nfbrd", n_fbrd - fb0, 0);
    expect_eq("t6_nwr", wa.size() - wb, 0);

    expect_eq("strobe_clash", n_clash, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
